// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider with stall/ready sequencing for the E stage.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             div_stall,
  output logic             div_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs;
  logic             neg_q, neg_r, skip;
  logic [WIDTH-1:0] abs_a, abs_b, rem_nx, quo_nx;
  logic [WIDTH:0]   trial;
  logic             accept, zero_div, early, last;

  always_comb begin
    abs_a    = (signed_div & a[WIDTH-1]) ? -a : a;
    abs_b    = (signed_div & b[WIDTH-1]) ? -b : b;
    zero_div = (b == '0);
`ifdef DIV_EARLY_OUT_EN
    early    = ~zero_div & (abs_a < abs_b);
`else
    early    = 1'b0;
`endif
    // skip: the cycle after DONE still carries the consumed instruction
    accept   = (state == IDLE) & start & ~annul & ~skip;
    last     = (cnt == CW'(WIDTH - 1));
    trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs};
    if (trial[WIDTH]) begin
      rem_nx = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nx  = state;
    div_stall = 1'b0;
    div_ready = 1'b0;
    case (state)
      IDLE: begin
        div_stall = accept & ~rst;
        if (accept) state_nx = (zero_div | early) ? DONE : BUSY;
      end
      BUSY: begin
        div_stall = ~annul;
        if (last) state_nx = DONE;
      end
      DONE: begin
        div_ready = ~annul;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (annul) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      skip      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      skip <= (state == DONE);
      if (accept) begin
        cnt   <= '0;
        rem_q <= '0;
        quo_q <= abs_a;
        dvs   <= abs_b;
        neg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= signed_div & a[WIDTH-1];
        // short paths return the raw dividend, so no sign fix-up applies
        if (zero_div) begin
          quotient  <= '1;
          remainder <= a;
        end else if (early) begin
          quotient  <= '0;
          remainder <= a;
        end
      end else if (state == BUSY && !annul) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt + 1'b1;
        if (last) begin
          quotient  <= neg_q ? -quo_nx : quo_nx;
          remainder <= neg_r ? -rem_nx : rem_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl (WIDTH=32).
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b, quotient, remainder;
  logic        div_stall, div_ready;
  int          checks = 0, failures = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .div_stall(div_stall),
    .div_ready(div_ready), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // start held until div_ready; cycle 0 is the cycle start is first seen
  task automatic run_div(input string tag, input logic sd, input logic [31:0] aa,
                         input logic [31:0] bb, input int exp_lat,
                         input logic [31:0] eq, input logic [31:0] er);
    int lat, nst;
    logic [31:0] q, r;
    lat = -1; nst = 0; q = '0; r = '0;
    signed_div = sd; a = aa; b = bb; start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      nst += int'(div_stall);
      if (div_ready) begin lat = c; q = quotient; r = remainder; end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stall"}, nst, exp_lat);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
  endtask

  initial begin
    int nrdy, rc0, rc1;
    logic [31:0] q0, q1, r1;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_stall", div_stall, 0);
    chk("rst_ready", div_ready, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1);
    run_div("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 33, 32'hFFFFFFF2, 32'hFFFFFFFE);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0);
    run_div("divu_big", 1'b0, 32'hFFFFFFFF, 32'd16, 33, 32'h0FFFFFFF, 32'd15);
    run_div("divu_by0", 1'b0, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5);
    run_div("div_by0", 1'b1, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFF9);

    // annul in the middle of the iteration
    signed_div = 1'b0; a = 32'd1000; b = 32'd10; start = 1'b1;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", div_stall, 0);
    chk("annul_ready", div_ready, 0);
    @(posedge clk); #1; annul = 1'b0; start = 1'b0;
    nrdy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); nrdy += int'(div_ready);
    end
    chk("annul_no_ready", nrdy, 0);
    chk("annul_hold_q", quotient, 32'hFFFFFFFF);
    @(posedge clk); #1;
    run_div("post_annul", 1'b0, 32'd1000, 32'd10, 33, 32'd100, 32'd0);

    // asynchronous reset mid-iteration, off the clock edge
    signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    for (int c = 0; c < 5; c++) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", div_stall, 0);
    chk("arst_ready", div_ready, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    start = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // back-to-back with start held through DONE and the following cycle
    nrdy = 0; rc0 = -1; rc1 = -1; q0 = '0; q1 = '0; r1 = '0;
    signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (div_ready) begin
        nrdy++;
        if (nrdy == 1) begin rc0 = c; q0 = quotient; end
        else begin rc1 = c; q1 = quotient; r1 = remainder; end
      end
      @(posedge clk); #1;
      if (nrdy == 1) begin a = 32'd50; b = 32'd5; end
      if (nrdy == 2) start = 1'b0;
    end
    chk("b2b_count", nrdy, 2);
    chk("b2b_lat0", rc0, 33);
    chk("b2b_q0", q0, 32'd14);
    chk("b2b_lat1", rc1, 68);
    chk("b2b_q1", q1, 32'd10);
    chk("b2b_r1", r1, 32'd0);

`ifdef DIV_EARLY_OUT_EN
    run_div("early_3_10", 1'b0, 32'd3, 32'd10, 1, 32'd0, 32'd3);
    run_div("early_m3_10", 1'b1, 32'hFFFFFFFD, 32'd10, 1, 32'd0, 32'hFFFFFFFD);
`else
    run_div("early_3_10", 1'b0, 32'd3, 32'd10, 33, 32'd0, 32'd3);
    run_div("early_m3_10", 1'b1, 32'hFFFFFFFD, 32'd10, 33, 32'd0, 32'hFFFFFFFD);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
